// File: rtl/shape_plotter.sv
// -----------------------------------------------------------------------------
// shape_plotter
//
// Consumer end of the square/peg drawing interface. The game controller hands
// over one shape-draw command through a start/busy/done handshake; this block
// then walks every pixel of the shape, one per clock, and drives the VGA
// adapter write port with registered x/y/colour/plot.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   command strobe, honoured only while idle (busy=0)
//   shape      in   0=20x20, 1=10x10, 2=feedback pegs 22x4, 3=erase 160x120
//   base_x     in   top-left x of the shape (forced to 0 for erase)
//   base_y     in   top-left y of the shape (forced to 0 for erase)
//   colour_in  in   pixel colour for shapes 0-2
//   peg_count  in   pegs drawn for shape 2, clamped to 4
//   busy       out  high while a command is in progress
//   done       out  one-cycle pulse when a command completes
//   x, y       out  pixel coordinate to the VGA adapter
//   colour     out  pixel colour to the VGA adapter
//   plot       out  VGA adapter write enable
// -----------------------------------------------------------------------------
module shape_plotter #(
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter logic [2:0]  ERASE_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] shape,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [2:0] colour_in,
    input  logic [2:0] peg_count,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);

    state_t     state_q, state_d;

    // latched command
    logic [1:0] shape_q, shape_d;
    logic [7:0] bx_q, bx_d;
    logic [6:0] by_q, by_d;
    logic [2:0] col_q, col_d;
    logic [2:0] pegs_q, pegs_d;

    // pixel walk counters
    logic [7:0] ox_q, ox_d;
    logic [6:0] oy_q, oy_d;
    logic [2:0] sub_q, sub_d;   // column within a 6-wide peg group
    logic [1:0] grp_q, grp_d;   // peg group index

    // registered outputs
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;

    logic       accept;
    logic [7:0] w_last;
    logic [6:0] h_last;
    logic       col_end;
    logic       last_px;
    logic [8:0] sx;
    logic [7:0] sy;
    logic       clipped;
    logic       peg_on;

    // busy_q gates acceptance so the done cycle itself never takes a command;
    // the first start honoured is in the cycle after done, when busy is low.
    assign accept = (state_q == S_IDLE) && start && !busy_q;

    always_comb begin
        w_last = 8'(SCREEN_W - 1);
        h_last = 7'(SCREEN_H - 1);
        case (shape_q)
            2'd0: begin w_last = 8'd19; h_last = 7'd19; end
            2'd1: begin w_last = 8'd9;  h_last = 7'd9;  end
            2'd2: begin w_last = 8'd21; h_last = 7'd3;  end
            default: ;
        endcase
    end

    assign col_end = (ox_q == w_last);
    assign last_px = col_end && (oy_q == h_last);

    // Sums are one bit wider than the outputs so the clip test sees overflow.
    assign sx      = {1'b0, bx_q} + {1'b0, ox_q};
    assign sy      = {1'b0, by_q} + {1'b0, oy_q};
    assign clipped = (sx >= SCREEN_W9) || (sy >= SCREEN_H8);
    assign peg_on  = (shape_q != 2'd2) ||
                     ((sub_q < 3'd4) && ({1'b0, grp_q} < pegs_q));

    // state and counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            shape_q <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            col_q   <= '0;
            pegs_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            sub_q   <= '0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            shape_q <= shape_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            col_q   <= col_d;
            pegs_q  <= pegs_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            sub_q   <= sub_d;
            grp_q   <= grp_d;
        end
    end

    // next-state and pixel walk
    always_comb begin
        state_d = state_q;
        shape_d = shape_q;
        bx_d    = bx_q;
        by_d    = by_q;
        col_d   = col_q;
        pegs_d  = pegs_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        sub_d   = sub_q;
        grp_d   = grp_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DRAW;
                    shape_d = shape;
                    bx_d    = (shape == 2'd3) ? 8'd0 : base_x;
                    by_d    = (shape == 2'd3) ? 7'd0 : base_y;
                    col_d   = colour_in;
                    pegs_d  = (peg_count > 3'd4) ? 3'd4 : peg_count;
                    ox_d    = '0;
                    oy_d    = '0;
                    sub_d   = '0;
                    grp_d   = '0;
                end
            end
            S_DRAW: begin
                if (last_px) begin
                    state_d = S_DONE;
                    ox_d    = '0;
                    oy_d    = '0;
                    sub_d   = '0;
                    grp_d   = '0;
                end else if (col_end) begin
                    ox_d    = '0;
                    oy_d    = oy_q + 7'd1;
                    sub_d   = '0;
                    grp_d   = '0;
                end else begin
                    ox_d    = ox_q + 8'd1;
                    if (sub_q == 3'd5) begin
                        sub_d = '0;
                        grp_d = grp_q + 2'd1;
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode. Outputs are registered, so they trail the walk by one
    // cycle: pixel n appears n+1 cycles after accept, done W*H+1 cycles after.
    always_comb begin
        busy_d   = accept || (state_q != S_IDLE);
        done_d   = (state_q == S_DONE);
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (state_q == S_DRAW) begin
            x_d      = sx[7:0];
            y_d      = sy[6:0];
            colour_d = (shape_q == 2'd3) ? ERASE_COLOUR : col_q;
            plot_d   = !clipped && peg_on;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

endmodule

// File: doc/shape_plotter.md
Name: shape_plotter

Overview:
- Consumer end of the square and peg offset interface.
- Accepts one shape-draw command (shape, base x/y, colour, peg count) through a start/busy/done handshake.
- Walks every pixel of the shape itself, one pixel per clock.
- Emits registered x, y, colour and plot straight to the VGA adapter write port.
- The game controller issues commands here and never touches pixel counters.

Parameters:
SCREEN_W, 160, visible width in pixels; x outputs stay below it
SCREEN_H, 120, visible height in pixels; y outputs stay below it
ERASE_COLOUR, 3'b000, colour used by the erase-screen shape

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
shape  in  2  0=big 20x20, 1=medium 10x10, 2=feedback pegs 22x4, 3=erase 160x120
base_x  in  8  top-left x of shape; ignored for shape 3 (origin 0)
base_y  in  7  top-left y of shape; ignored for shape 3
colour_in  in  3  pixel colour for shapes 0-2
peg_count  in  3  pegs drawn for shape 2; values >4 treated as 4
busy  out  1  high while a command is in progress
done  out  1  one-cycle pulse when a command completes
x  out  8  pixel x to VGA adapter
y  out  7  pixel y to VGA adapter
colour  out  3  pixel colour to VGA adapter
plot  out  1  write enable to VGA adapter

Behaviour:
- Reset values, applied on the first rising edge with reset=1:
  - state=IDLE; busy=0; done=0; plot=0; x=0; y=0; colour=0.
  - All internal counters are 0.
- States:
  - IDLE: busy=0, plot=0.
  - DRAW: busy=1.
  - DONE: busy=1, done=1 for exactly one cycle, plot=0; then IDLE.
- Command capture:
  - start=1 in IDLE latches shape, base_x, base_y, colour_in, and peg_count (clamped to 4) on that edge.
  - The FSM enters DRAW. Inputs may then change freely.
  - start while busy=1 is ignored and is not queued.
- Pixel walk:
  - Offset counters ox (column) and oy (row) start at 0.
  - Each DRAW cycle emits one pixel, then ox increments.
  - At ox=W-1, ox wraps to 0 and oy increments.
  - At ox=W-1 and oy=H-1 the FSM goes to DONE.
  - Counters are separate row/column registers. No divide or modulo.
- Shape sizes (W x H = DRAW cycles):
  - shape 0: 20x20 = 400.
  - shape 1: 10x10 = 100.
  - shape 2: 22x4 = 88.
  - shape 3: 160x120 = 19200.
- Latency:
  - First pixel appears on x/y/plot in the cycle after start is accepted.
  - The last pixel is followed by done in the next cycle.
  - A new start is accepted in the cycle after done, when busy=0.
  - Total command time from the accept edge to the done pulse is W*H+1 cycles.
- Output per DRAW cycle:
  - x = base_x+ox; y = base_y+oy.
  - Additions are 9/8 bits wide internally. x and y are truncated only after the clip check.
  - colour = latched colour, or ERASE_COLOUR for shape 3.
  - plot = 1 unless that pixel is masked or clipped.
- Peg mask (shape 2): columns are grouped as 4 peg columns followed by a 2-column gap.
  - peg index p = column group 0..3, tracked with a 0..5 sub-counter and a 0..3 group counter.
  - Pixel is plotted only if sub<4 and p<peg_count.
  - peg_count=0 still takes 88 cycles with plot=0 throughout, and done still pulses.
  - Columns 22..23 never occur; the last group has no trailing gap.
- Clipping:
  - If base_x+ox >= SCREEN_W or base_y+oy >= SCREEN_H, then plot=0 for that cycle.
  - The cycle is still consumed, so timing is independent of position.
- When plot=0, x/y/colour hold don't-care but defined values: the unclipped truncated sum.
- Reset mid-command returns to IDLE on the next edge: plot=0, done never asserted for the aborted command.
- start and reset in the same cycle: reset wins; the command is dropped.

Test Plan:
- Reset then shape=1, base=(30,40), colour=3'b101 → 100 plot cycles covering x 30..39, y 40..49 in row-major order, colour 101; done at cycle 101 after accept; busy low at 102.
- shape=2, base=(100,10), peg_count=3 → 88 DRAW cycles; plot high only at x∈{100-103,106-109,112-115}, y 10..13 (48 pixels); x 104,105,110,111,116..121 never plotted.
- shape=2, peg_count=7 → identical to peg_count=4: 64 plotted pixels; peg_count=0 → 0 plots, done still after 88 cycles.
- shape=0, base=(150,110) → 400 cycles; plot only for x 150..159, y 110..119 (100 pixels); x never ≥160 with plot=1.
- shape=3 with colour_in=3'b111 → 19200 plots, all colour 000, last pixel (159,119); start pulses mid-erase ignored; only one done.
- Assert reset at pixel 50 of shape 0 → plot=0 and busy=0 on the next edge, no done; a subsequent command runs from pixel (base_x,base_y).
